// File: rtl/score_ram_arbiter.sv
// rtl/score_ram_arbiter.sv - display/host arbiter for the single-port score-sprite RAM
module score_ram_arbiter #(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 5120,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              host_chipselect,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_writedata,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_readdatavalid,
    input  logic              freeze,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOST_MAX_WAIT);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              tag_valid;
    logic              tag_host;
    logic              tag_oor;

    logic              host_active;
    logic              host_req;
    logic              starved;
    logic              disp_grant;
    logic              host_grant;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oor;
    logic [DATA_W-1:0] read_data;

    // A frozen write does not count as a request, so it neither wins nor ages starve_cnt.
    assign host_active = host_chipselect & (host_read | host_write);
    assign host_req    = host_active & ~(host_write & freeze);
    assign starved     = (starve_cnt == CNT_MAX);

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    assign disp_grant = reset_n & disp_req & (~host_req | ~starved);
    assign host_grant = reset_n & host_req & (~disp_req | starved);
    assign any_grant  = disp_grant | host_grant;

    assign sel_addr = host_grant ? host_address : disp_addr;
    assign sel_oor  = ({1'b0, sel_addr} >= DEPTH_V);

    assign disp_ack         = disp_grant;
    assign host_waitrequest = ~reset_n | (host_active & ~host_grant);

    assign ram_address   = any_grant  ? sel_addr       : addr_q;
    assign ram_writedata = host_grant ? host_writedata : wdata_q;
    assign ram_wren      = host_grant & host_write & ~sel_oor;

    // Out-of-range reads return zero in place of whatever the RAM drives.
    assign read_data          = tag_oor ? '0 : ram_readdata;
    assign disp_rvalid        = tag_valid & ~tag_host;
    assign host_readdatavalid = tag_valid & tag_host;
    assign disp_rdata         = disp_rvalid        ? read_data : disp_rdata_q;
    assign host_readdata      = host_readdatavalid ? read_data : host_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (host_grant || !host_req) begin
            starve_cnt <= '0;
        end else if (disp_grant && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (any_grant) begin
                addr_q <= sel_addr;
            end
            if (host_grant) begin
                wdata_q <= host_writedata;
            end
        end
    end

    // Read tag: one entry suffices because the RAM returns data exactly one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= 1'b0;
            tag_host  <= 1'b0;
            tag_oor   <= 1'b0;
        end else begin
            tag_valid <= disp_grant | (host_grant & ~host_write);
            tag_host  <= host_grant;
            tag_oor   <= sel_oor;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            if (disp_rvalid) begin
                disp_rdata_q <= read_data;
            end
            if (host_readdatavalid) begin
                host_rdata_q <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_score_ram_arbiter.sv
// tb/tb_score_ram_arbiter.sv - directed self-checking bench for score_ram_arbiter
module tb_score_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic        disp_ack;
    logic [7:0]  disp_rdata;
    logic        disp_rvalid;
    logic        host_chipselect;
    logic        host_read;
    logic        host_write;
    logic [12:0] host_address;
    logic [7:0]  host_writedata;
    logic        host_waitrequest;
    logic [7:0]  host_readdata;
    logic        host_readdatavalid;
    logic        freeze;
    logic [12:0] ram_address;
    logic [7:0]  ram_writedata;
    logic        ram_wren;
    logic [7:0]  ram_readdata;

    logic [7:0]  mem [0:8191];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    score_ram_arbiter dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .disp_req           (disp_req),
        .disp_addr          (disp_addr),
        .disp_ack           (disp_ack),
        .disp_rdata         (disp_rdata),
        .disp_rvalid        (disp_rvalid),
        .host_chipselect    (host_chipselect),
        .host_read          (host_read),
        .host_write         (host_write),
        .host_address       (host_address),
        .host_writedata     (host_writedata),
        .host_waitrequest   (host_waitrequest),
        .host_readdata      (host_readdata),
        .host_readdatavalid (host_readdatavalid),
        .freeze             (freeze),
        .ram_address        (ram_address),
        .ram_writedata      (ram_writedata),
        .ram_wren           (ram_wren),
        .ram_readdata       (ram_readdata)
    );

    // RAM model with registered read; contents are preloaded whenever reset is low.
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[0]    <= 8'hA0;
            mem[1]    <= 8'hA1;
            mem[2]    <= 8'hA2;
            mem[3]    <= 8'hA3;
            mem[5119] <= 8'h3C;
            mem[6000] <= 8'h77;
        end else if (ram_wren) begin
            mem[ram_address] <= ram_writedata;
        end
        ram_readdata <= mem[ram_address];
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        disp_req        = 1'b0;
        disp_addr       = '0;
        host_chipselect = 1'b0;
        host_read       = 1'b0;
        host_write      = 1'b0;
        host_address    = '0;
        host_writedata  = '0;
        freeze          = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_inputs();
        disp_req        = 1'b1;
        host_chipselect = 1'b1;
        host_read       = 1'b1;
        host_address    = 13'd7;
        repeat (3) next_cycle();
        #3;
        total_cnt++; if (disp_ack !== 1'b0) $display("FAIL reset_disp_ack got %b want 0", disp_ack); else pass_cnt++;
        total_cnt++; if (host_waitrequest !== 1'b1) $display("FAIL reset_waitrequest got %b want 1", host_waitrequest); else pass_cnt++;
        total_cnt++; if (ram_wren !== 1'b0) $display("FAIL reset_wren got %b want 0", ram_wren); else pass_cnt++;
        total_cnt++; if (ram_address !== 13'd0) $display("FAIL reset_ram_address got %0d want 0", ram_address); else pass_cnt++;
        total_cnt++; if ({disp_rvalid, host_readdatavalid} !== 2'b00) $display("FAIL reset_rvalid got %b want 00", {disp_rvalid, host_readdatavalid}); else pass_cnt++;
        total_cnt++; if ({disp_rdata, host_readdata, ram_writedata} !== 24'h0) $display("FAIL reset_data got %h want 000000", {disp_rdata, host_readdata, ram_writedata}); else pass_cnt++;
        idle_inputs();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_display_only;
        for (int c = 0; c < 6; c++) begin
            disp_req  = (c < 4);
            disp_addr = 13'(c < 4 ? c : 0);
            #3;
            total_cnt++; if (disp_ack !== (c < 4)) $display("FAIL disp_ack c%0d got %b want %b", c, disp_ack, (c < 4)); else pass_cnt++;
            if (c < 4) begin
                total_cnt++; if (ram_address !== 13'(c)) $display("FAIL disp_ram_address c%0d got %0d want %0d", c, ram_address, c); else pass_cnt++;
            end
            total_cnt++; if (disp_rvalid !== (c >= 1 && c <= 4)) $display("FAIL disp_rvalid c%0d got %b", c, disp_rvalid); else pass_cnt++;
            if (c >= 1) begin
                total_cnt++;
                if (disp_rdata !== 8'hA0 + 8'(c >= 5 ? 3 : c - 1)) $display("FAIL disp_rdata c%0d got %h want %h", c, disp_rdata, 8'hA0 + 8'(c >= 5 ? 3 : c - 1));
                else pass_cnt++;
            end
            total_cnt++; if ({host_readdatavalid, host_waitrequest} !== 2'b00) $display("FAIL disp_host_idle c%0d got %b want 00", c, {host_readdatavalid, host_waitrequest}); else pass_cnt++;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_host_write_read;
        host_chipselect = 1'b1;
        host_write      = 1'b1;
        host_address    = 13'd100;
        host_writedata  = 8'h5C;
        #3;
        total_cnt++; if (host_waitrequest !== 1'b0) $display("FAIL hw_waitrequest got %b want 0", host_waitrequest); else pass_cnt++;
        total_cnt++; if ({ram_wren, ram_address, ram_writedata} !== {1'b1, 13'd100, 8'h5C}) $display("FAIL hw_ram_drive got %b/%0d/%h want 1/100/5c", ram_wren, ram_address, ram_writedata); else pass_cnt++;
        next_cycle();
        host_write = 1'b0;
        host_read  = 1'b1;
        #3;
        total_cnt++; if ({host_waitrequest, ram_wren} !== 2'b00) $display("FAIL hr_grant got %b want 00", {host_waitrequest, ram_wren}); else pass_cnt++;
        total_cnt++; if (host_readdatavalid !== 1'b0) $display("FAIL hr_early_valid got %b want 0", host_readdatavalid); else pass_cnt++;
        next_cycle();
        idle_inputs();
        #3;
        total_cnt++; if (host_readdatavalid !== 1'b1) $display("FAIL hr_valid got %b want 1", host_readdatavalid); else pass_cnt++;
        total_cnt++; if (host_readdata !== 8'h5C) $display("FAIL hr_data got %h want 5c", host_readdata); else pass_cnt++;
        total_cnt++; if (disp_rvalid !== 1'b0) $display("FAIL hr_disp_rvalid got %b want 0", disp_rvalid); else pass_cnt++;
        next_cycle();
        #3;
        total_cnt++; if ({host_readdatavalid, host_readdata} !== {1'b0, 8'h5C}) $display("FAIL hr_hold got %b/%h want 0/5c", host_readdatavalid, host_readdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_contention;
        disp_req        = 1'b1;
        disp_addr       = 13'd3;
        host_chipselect = 1'b1;
        host_read       = 1'b1;
        host_address    = 13'd100;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) idle_inputs();
            #3;
            if (c < 10) begin
                total_cnt++; if (disp_ack !== (c % 5 != 4)) $display("FAIL fair_disp_ack c%0d got %b want %b", c, disp_ack, (c % 5 != 4)); else pass_cnt++;
                total_cnt++; if (host_waitrequest !== (c % 5 != 4)) $display("FAIL fair_waitrequest c%0d got %b want %b", c, host_waitrequest, (c % 5 != 4)); else pass_cnt++;
            end
            total_cnt++; if (host_readdatavalid !== (c > 0 && c % 5 == 0)) $display("FAIL fair_host_rvalid c%0d got %b", c, host_readdatavalid); else pass_cnt++;
            total_cnt++; if (disp_rvalid !== (c > 0 && c % 5 != 0)) $display("FAIL fair_disp_rvalid c%0d got %b", c, disp_rvalid); else pass_cnt++;
            if (c == 5) begin
                total_cnt++; if (host_readdata !== 8'h5C) $display("FAIL fair_host_data got %h want 5c", host_readdata); else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++; if (disp_rdata !== 8'hA3) $display("FAIL fair_disp_data got %h want a3", disp_rdata); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_out_of_range;
        host_chipselect = 1'b1;
        host_write      = 1'b1;
        host_address    = 13'd5120;
        host_writedata  = 8'hFF;
        #3;
        total_cnt++; if ({host_waitrequest, ram_wren} !== 2'b00) $display("FAIL oor_write got %b want 00", {host_waitrequest, ram_wren}); else pass_cnt++;
        next_cycle();
        host_write   = 1'b0;
        host_read    = 1'b1;
        host_address = 13'd6000;
        #3;
        total_cnt++; if (host_waitrequest !== 1'b0) $display("FAIL oor_read_wait got %b want 0", host_waitrequest); else pass_cnt++;
        next_cycle();
        idle_inputs();
        disp_req  = 1'b1;
        disp_addr = 13'd5119;
        #3;
        total_cnt++; if ({host_readdatavalid, host_readdata} !== {1'b1, 8'h00}) $display("FAIL oor_read_data got %b/%h want 1/00", host_readdatavalid, host_readdata); else pass_cnt++;
        total_cnt++; if (disp_ack !== 1'b1) $display("FAIL oor_disp_ack got %b want 1", disp_ack); else pass_cnt++;
        next_cycle();
        idle_inputs();
        #3;
        total_cnt++; if ({disp_rvalid, disp_rdata} !== {1'b1, 8'h3C}) $display("FAIL oor_disp_edge got %b/%h want 1/3c", disp_rvalid, disp_rdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_freeze;
        freeze          = 1'b1;
        host_chipselect = 1'b1;
        host_write      = 1'b1;
        host_address    = 13'd200;
        host_writedata  = 8'h11;
        disp_req        = 1'b1;
        disp_addr       = 13'd0;
        for (int c = 0; c < 10; c++) begin
            #3;
            total_cnt++; if ({host_waitrequest, disp_ack, ram_wren} !== 3'b110) $display("FAIL freeze_stall c%0d got %b want 110", c, {host_waitrequest, disp_ack, ram_wren}); else pass_cnt++;
            next_cycle();
        end
        freeze   = 1'b0;
        disp_req = 1'b0;
        #3;
        total_cnt++; if ({host_waitrequest, ram_wren, ram_address} !== {2'b01, 13'd200}) $display("FAIL freeze_release got %b/%b/%0d want 0/1/200", host_waitrequest, ram_wren, ram_address); else pass_cnt++;
        next_cycle();
        host_write = 1'b0;
        host_read  = 1'b1;
        next_cycle();
        idle_inputs();
        #3;
        total_cnt++; if ({host_readdatavalid, host_readdata} !== {1'b1, 8'h11}) $display("FAIL freeze_readback got %b/%h want 1/11", host_readdatavalid, host_readdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid_read;
        disp_req  = 1'b1;
        disp_addr = 13'd1;
        #3;
        total_cnt++; if (disp_ack !== 1'b1) $display("FAIL rst_mid_ack got %b want 1", disp_ack); else pass_cnt++;
        next_cycle();
        reset_n = 1'b0;
        idle_inputs();
        #3;
        total_cnt++; if ({disp_rvalid, host_readdatavalid} !== 2'b00) $display("FAIL rst_mid_rvalid got %b want 00", {disp_rvalid, host_readdatavalid}); else pass_cnt++;
        total_cnt++; if ({disp_rdata, ram_address, host_waitrequest} !== {8'h00, 13'd0, 1'b1}) $display("FAIL rst_mid_outputs got %h/%0d/%b want 00/0/1", disp_rdata, ram_address, host_waitrequest); else pass_cnt++;
        next_cycle();
        reset_n = 1'b1;
        #3;
        total_cnt++; if (disp_rvalid !== 1'b0) $display("FAIL rst_mid_release_rvalid got %b want 0", disp_rvalid); else pass_cnt++;
        next_cycle();
        disp_req  = 1'b1;
        disp_addr = 13'd2;
        next_cycle();
        idle_inputs();
        #3;
        total_cnt++; if ({disp_rvalid, disp_rdata} !== {1'b1, 8'hA2}) $display("FAIL rst_mid_resume got %b/%h want 1/a2", disp_rvalid, disp_rdata); else pass_cnt++;
        next_cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_display_only();
        test_host_write_read();
        test_contention();
        test_out_of_range();
        test_freeze();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/score_ram_arbiter.md
Name: score_ram_arbiter

Overview:
- Shares the single-port score-sprite RAM (5120 x 8, 13-bit address) between two requesters:
  - the display glyph fetcher, which is latency-critical and has default priority;
  - the HPS Avalon-MM host port, used for sprite upload and readback.
- Grants at most one RAM operation per cycle.
- Tags each in-flight read and routes the returning data to its owner.
- Bounds host starvation with a fairness counter.

Parameters:
- ADDR_W, 13, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 5120, valid word count; addresses >= DEPTH are out of range.
- HOST_MAX_WAIT, 4, maximum consecutive display grants allowed while a host request is pending.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- disp_req  in  1  display read request, one word per asserted cycle
- disp_addr  in  ADDR_W  display read address
- disp_ack  out  1  display request accepted this cycle (combinational)
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse
- host_chipselect  in  1  Avalon chipselect
- host_read  in  1  Avalon read
- host_write  in  1  Avalon write
- host_address  in  ADDR_W  Avalon word address
- host_writedata  in  DATA_W  Avalon write data
- host_waitrequest  out  1  Avalon waitrequest (combinational)
- host_readdata  out  DATA_W  Avalon read data
- host_readdatavalid  out  1  Avalon readdatavalid, one-cycle pulse
- freeze  in  1  while high, host writes stall; host reads and display reads continue
- ram_address  out  ADDR_W  to RAM address_a
- ram_writedata  out  DATA_W  to RAM data_a
- ram_wren  out  1  to RAM wren_a
- ram_readdata  in  DATA_W  from RAM q_a; valid one cycle after address is presented

Behaviour:
- Request definitions:
  - host_req = host_chipselect & (host_read | host_write) & ~(host_write & freeze).
  - If host_read and host_write are both high, the access is treated as a write.
- Arbitration (combinational, per cycle):
  - If disp_req and host_req are both high and starve_cnt < HOST_MAX_WAIT, grant display.
  - If both are high and starve_cnt == HOST_MAX_WAIT, grant host.
  - A single requester is always granted.
  - disp_ack = display grant.
  - host_waitrequest = host_chipselect & (host_read | host_write) & ~host_grant.
- starve_cnt (registered, saturating at HOST_MAX_WAIT):
  - increments on a display grant while host_req is high;
  - clears on a host grant or when host_req is low.
- RAM drive:
  - ram_address and ram_writedata come from the granted requester; otherwise they hold their last value.
  - ram_wren = host grant & host_write & in-range address.
- Read return path:
  - Tag register {valid, owner, oor} is captured on each granted read.
  - The next cycle, the tag steers ram_readdata to disp_rdata/disp_rvalid or to host_readdata/host_readdatavalid.
  - Latency from grant to rvalid is exactly 1 cycle; back-to-back reads sustain 1 word/cycle.
  - rdata registers hold their value when rvalid is low.
- Out-of-range address (>= DEPTH):
  - Writes are accepted (waitrequest drops) and discarded, with no ram_wren.
  - Reads return 0x00 with normal 1-cycle valid timing, and the RAM output is ignored.
- Hazards:
  - A write followed by a read of the same address on the next grant returns the new data.
  - Read-during-write cannot occur because there is one operation per cycle.
- Reset (reset_n low, asynchronous):
  - Registered outputs clear: disp_rvalid=0, host_readdatavalid=0, disp_rdata=0, host_readdata=0, ram_address=0, ram_writedata=0.
  - ram_wren=0, disp_ack=0, host_waitrequest=1 while reset is held.
  - starve_cnt=0, tag cleared.
  - A read in flight when reset asserts produces no valid pulse after release.
- freeze rises while a host write is pending: waitrequest stays high until freeze falls, then normal arbitration resumes.

Test Plan:
- Display only: disp_req held 4 cycles at addresses 0,1,2,3 with RAM preloaded 0xA0..0xA3 -> disp_ack each cycle; disp_rvalid pulses cycles 1..4 with data 0xA0..0xA3; host outputs idle.
- Host write then read: write 0x5C to address 100, then read address 100 with no display traffic -> ram_wren for 1 cycle; waitrequest low both cycles; readdatavalid one cycle after the read grant with 0x5C.
- Contention and fairness: disp_req continuous, host read pending from cycle 0 -> 4 display grants, host granted on cycle 4; host_readdatavalid on cycle 5; starve_cnt returns to 0 and the pattern repeats every 5 cycles.
- Out of range: host write 0xFF to address 5120, then read address 6000 -> no ram_wren; readdata 0x00 with valid 1 cycle after grant; display read at 5119 unaffected.
- freeze: freeze=1 with host write pending for 10 cycles -> waitrequest high, display reads served; freeze drops -> write granted the next cycle.
- Reset mid-read: assert reset_n low on the cycle after a display grant -> no disp_rvalid pulse; all outputs at their reset values; normal traffic resumes after release.
